// File: rtl/nibble_serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl (plus leaf FA_4bits_RCA)
//  Description : Multi-cycle WIDTH-bit adder. A single 4-bit ripple-carry
//                adder is time-shared across the operand, one nibble per
//                clock, with the inter-nibble carry held in a register.
//                Valid/ready handshakes on both the operand and result side.
//  Ports       : clk          - clock, rising edge
//                rst_n        - synchronous active-low reset
//                i_in_valid   - operand request valid
//                o_in_ready   - controller idle, operands will be accepted
//                i_a, i_b     - operands, sampled only on accept
//                i_cin        - carry-in to nibble 0, sampled only on accept
//                o_out_valid  - o_sum/o_cout valid (held until i_out_ready)
//                i_out_ready  - consumer takes the result
//                o_sum        - a + b + cin mod 2^WIDTH
//                o_cout       - carry out of the most significant nibble
//                o_busy       - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// FA_4bits_RCA: 4-bit ripple-carry adder built from a chain of full adders.
// ----------------------------------------------------------------------------
module FA_4bits_RCA (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[4];

endmodule

// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl: sequencer around one FA_4bits_RCA.
// ----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = $clog2(N);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [IDX_W+1:0] w_base;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;

  // Accept is qualified by state only; o_in_ready is just the IDLE decode.
  assign w_accept = (r_state == c_IDLE) && i_in_valid;
  assign w_last   = (r_idx == c_LAST);

  // Bit offset of the current nibble (idx * 4).
  assign w_base = {r_idx, 2'b00};

  FA_4bits_RCA u_rca (
    .i_a    (r_a[w_base +: 4]),
    .i_b    (r_b[w_base +: 4]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (i_in_valid)  w_state_nxt = c_RUN;
      c_RUN:   if (w_last)      w_state_nxt = c_DONE;
      c_DONE:  if (i_out_ready) w_state_nxt = c_IDLE;
      default:                  w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode, purely from the state register
  // --------------------------------------------------------------------------
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      c_IDLE: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
      end
      c_DONE:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == c_RUN) begin
      r_sum[w_base +: 4] <= w_slice_sum;
      r_carry            <= w_slice_cout;
      // Hold idx on the last nibble so it never wraps inside RUN.
      if (w_last) begin
        r_cout <= w_slice_cout;
      end else begin
        r_idx  <= r_idx + c_ONE;
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule
`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencer that performs a WIDTH-bit addition over several clock cycles. It time-shares a single instance of the team's 4-bit ripple-carry adder (FA_4bits_RCA), one nibble per cycle, and carries between nibbles in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area against a full-width combinational adder.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and ≥ 8; N = WIDTH/4 nibbles.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A, sampled only on accept.
- b  input  WIDTH  operand B, sampled only on accept.
- cin  input  1  carry-in to nibble 0, sampled only on accept.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of the MSB nibble.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Exactly one FA_4bits_RCA instance. It is fed by the selected nibble of the operand registers and by the carry register.
- States:
  - IDLE: in_ready=1.
  - RUN: one nibble per cycle.
  - DONE: out_valid=1, result held.
- IDLE → RUN on in_valid && in_ready:
  - capture a and b into operand registers; capture cin into the carry register;
  - idx ← 0; sum ← 0; cout ← 0.
- RUN, each edge:
  - sum[4*idx+3:4*idx] ← slice sum;
  - carry ← slice carry;
  - idx ← idx+1.
  - When idx = N-1 at the edge: state → DONE, and cout ← slice carry.
- DONE → IDLE on out_valid && out_ready. No operand accept occurs in DONE, including the same cycle as the result handshake.
- in_valid in RUN/DONE is ignored (in_ready=0). Producer need not hold a/b/cin after the accept edge.
- Arithmetic:
  - {cout, sum} = a + b + cin, exact (WIDTH+1 bits).
  - Overflow is reported only through cout; no saturation.
- idx width is clog2(N). idx never wraps while in RUN; it is reset to 0 on accept.
- sum/cout may change during RUN. They are meaningful only while out_valid=1, and are stable for all DONE cycles.
- Reset (rst_n=0 at an edge), from any state including mid-RUN or DONE:
  - state ← IDLE; idx ← 0; carry ← 0; sum ← 0; cout ← 0;
  - the in-flight operation is discarded with no out_valid.
- Reset values:
  - in_ready=1 (state IDLE);
  - out_valid=0, busy=0, sum=0, cout=0.
- in_ready, out_valid and busy are decoded directly from the state register (no combinational path from in_valid/out_ready).

## Timing
- Accept at edge k:
  - RUN for N cycles; nibble i is registered at edge k+1+i;
  - state DONE after edge k+N, so out_valid rises N cycles after the accepting edge.
  - WIDTH=16: 4 cycles.
- out_valid held until the first edge with out_ready=1. It deasserts and in_ready asserts after that edge.
- Minimum issue interval with out_ready tied high: N+2 cycles (N RUN + 1 DONE + 1 IDLE).
- Critical path: one 4-bit ripple chain plus the nibble mux, independent of WIDTH.

## Test plan
- Reset: rst_n=0 for 2 edges with in_valid=1, a=b=0xFFFF → in_ready=1, out_valid=0, busy=0, sum=0x0000, cout=0; no operation started after release until a fresh accept.
- Basic (WIDTH=16): a=0x1234, b=0x4321, cin=0 → out_valid exactly 4 cycles after accept, sum=0x5555, cout=0.
- Full ripple across all nibbles: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1; a=0x0FFF, b=0x0001, cin=0 → sum=0x1000, cout=0.
- Backpressure: out_ready=0 for 3 cycles in DONE with a=0xA5A5, b=0x5A5A, cin=1 → out_valid=1, sum=0x0000, cout=1 stable all 3 cycles, in_ready=0, in_valid pulses ignored; out_ready=1 → next edge out_valid=0, in_ready=1.
- Reset mid-operation: rst_n=0 at the 2nd RUN edge → next state IDLE, sum=0, out_valid never asserts; then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1.
- Back-to-back with out_ready=1, in_valid=1: 3 ops (0x0001+0x0001, 0x00FF+0x0001, 0xFFFE+0x0001) → results 0x0002/0, 0x0100/0, 0xFFFF/0, accepts spaced exactly 6 cycles; repeat the first op at WIDTH=8 → 2-cycle latency.
